// File: rtl/dcache_pkg.sv
// Shared dcache geometry, payload typedefs and data-array arbiter encoding.
package dcache_pkg;

  localparam int unsigned DCACHE_LINE_WIDTH      = 128;
  localparam int unsigned DCACHE_NUM_WORDS       = 64;
  localparam int unsigned DCACHE_NUM_WAYS        = 4;
  localparam int unsigned DCACHE_WR_STARVE_LIMIT = 4;

  localparam int unsigned DCACHE_IDX_W       = $clog2(DCACHE_NUM_WORDS);
  localparam int unsigned DCACHE_BE_W        = DCACHE_LINE_WIDTH / 8;
  // Wide enough for the largest legal starvation limit (15).
  localparam int unsigned DCACHE_STARVE_CNT_W = 4;

  typedef logic [DCACHE_IDX_W-1:0]    dcache_idx_t;
  typedef logic [DCACHE_NUM_WAYS-1:0] dcache_way_oh_t;
  typedef logic [DCACHE_BE_W-1:0]     dcache_be_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_READ  = 2'd1,
    ARB_WRITE = 2'd2
  } dcache_arb_e;

endpackage

// File: rtl/dcache_data_way.sv
// One cache way: single-port byte-enabled BRAM with a registered read address.
module dcache_data_way
  import dcache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DCACHE_LINE_WIDTH,
  parameter int unsigned NUM_WORDS  = DCACHE_NUM_WORDS
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         we_i,
  input  logic [DATA_WIDTH/8-1:0]      be_i,
  input  logic [$clog2(NUM_WORDS)-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0]        wdata_i,
  input  logic                         re_i,
  output logic [DATA_WIDTH-1:0]        rdata_o
);

  localparam int unsigned IDX_W = $clog2(NUM_WORDS);
  localparam int unsigned BE_W  = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];
  logic [IDX_W-1:0]      addr_q;

  // Contents are intentionally left uninitialised so the array maps onto BRAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (be_i[b]) mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q <= '0;
    end else if (re_i) begin
      addr_q <= addr_i;
    end
  end

  assign rdata_o = mem[addr_q];

endmodule

// File: rtl/dcache_data_array.sv
// Multi-way dcache data store with read/write arbiter and write-starvation guard.
// Optional output register stage: RISCMAKERS_DCACHE_DATA_OUT_REG_EN.
module dcache_data_array
  import dcache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = DCACHE_LINE_WIDTH,
  parameter int unsigned NUM_WORDS       = DCACHE_NUM_WORDS,
  parameter int unsigned NUM_WAYS        = DCACHE_NUM_WAYS,
  parameter int unsigned WR_STARVE_LIMIT = DCACHE_WR_STARVE_LIMIT
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           rd_req_i,
  input  logic [$clog2(NUM_WORDS)-1:0]   rd_idx_i,
  output logic                           rd_gnt_o,
  output logic                           rd_vld_o,
  output logic [NUM_WAYS*DATA_WIDTH-1:0] rd_data_o,
  input  logic                           wr_req_i,
  input  logic [$clog2(NUM_WORDS)-1:0]   wr_idx_i,
  input  logic [NUM_WAYS-1:0]            wr_way_i,
  input  logic [DATA_WIDTH/8-1:0]        wr_be_i,
  input  logic [DATA_WIDTH-1:0]          wr_data_i,
  output logic                           wr_gnt_o
);

  localparam int unsigned IDX_W = $clog2(NUM_WORDS);
  localparam int unsigned CNT_W = DCACHE_STARVE_CNT_W;

  dcache_arb_e                   arb_sel;
  logic [CNT_W-1:0]              starve_cnt_q;
  logic [CNT_W-1:0]              starve_cnt_d;
  logic                          rd_vld_q;
  logic [IDX_W-1:0]              ram_addr;
  logic [NUM_WAYS*DATA_WIDTH-1:0] ram_rdata;

  // Reads win by default; a write that has waited WR_STARVE_LIMIT cycles takes the slot.
  always_comb begin
    arb_sel      = ARB_IDLE;
    starve_cnt_d = starve_cnt_q;
    if (!rst_i) begin
      if (rd_req_i && wr_req_i) begin
        if (starve_cnt_q >= CNT_W'(WR_STARVE_LIMIT)) begin
          arb_sel = ARB_WRITE;
        end else begin
          arb_sel      = ARB_READ;
          starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
      end else if (rd_req_i) begin
        arb_sel = ARB_READ;
      end else if (wr_req_i) begin
        arb_sel = ARB_WRITE;
      end
      if (arb_sel == ARB_WRITE) starve_cnt_d = '0;
    end
  end

  assign rd_gnt_o = (arb_sel == ARB_READ);
  assign wr_gnt_o = (arb_sel == ARB_WRITE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt_q <= '0;
      rd_vld_q     <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_vld_q     <= rd_gnt_o;
    end
  end

  // Grants are exclusive, so the single RAM port is shared by muxing the index.
  assign ram_addr = wr_gnt_o ? wr_idx_i : rd_idx_i;

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    dcache_data_way #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_WORDS  (NUM_WORDS)
    ) u_way (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .we_i    (wr_gnt_o & wr_way_i[w]),
      .be_i    (wr_be_i),
      .addr_i  (ram_addr),
      .wdata_i (wr_data_i),
      .re_i    (rd_gnt_o),
      .rdata_o (ram_rdata[w*DATA_WIDTH +: DATA_WIDTH])
    );
  end

`ifdef RISCMAKERS_DCACHE_DATA_OUT_REG_EN
  logic                           rd_vld_out_q;
  logic [NUM_WAYS*DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_vld_out_q <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      rd_vld_out_q <= rd_vld_q;
      if (rd_vld_q) rd_data_q <= ram_rdata;
    end
  end

  assign rd_vld_o  = rd_vld_out_q & ~rst_i;
  assign rd_data_o = rd_data_q;
`else
  // Reset suppresses a valid pulse still in flight from a grant before reset.
  assign rd_vld_o  = rd_vld_q & ~rst_i;
  assign rd_data_o = ram_rdata;
`endif

endmodule

// File: tb/tb_dcache_data_array.sv
// Scoreboard bench for dcache_data_array (either build of the output-register option).
module tb_dcache_data_array;
  import dcache_pkg::*;

  localparam int unsigned DW     = DCACHE_LINE_WIDTH;
  localparam int unsigned NW     = DCACHE_NUM_WAYS;
  localparam int unsigned NWORDS = DCACHE_NUM_WORDS;
  localparam int unsigned BW     = DW / 8;
`ifdef RISCMAKERS_DCACHE_DATA_OUT_REG_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rd_req = 1'b0;
  dcache_idx_t       rd_idx = '0;
  logic              rd_gnt;
  logic              rd_vld;
  logic [NW*DW-1:0]  rd_data;
  logic              wr_req = 1'b0;
  dcache_idx_t       wr_idx = '0;
  dcache_way_oh_t    wr_way = '0;
  dcache_be_t        wr_be = '0;
  logic [DW-1:0]     wr_data = '0;
  logic              wr_gnt;

  dcache_data_array #(
    .DATA_WIDTH      (DW),
    .NUM_WORDS       (NWORDS),
    .NUM_WAYS        (NW),
    .WR_STARVE_LIMIT (DCACHE_WR_STARVE_LIMIT)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .rd_req_i  (rd_req),
    .rd_idx_i  (rd_idx),
    .rd_gnt_o  (rd_gnt),
    .rd_vld_o  (rd_vld),
    .rd_data_o (rd_data),
    .wr_req_i  (wr_req),
    .wr_idx_i  (wr_idx),
    .wr_way_i  (wr_way),
    .wr_be_i   (wr_be),
    .wr_data_i (wr_data),
    .wr_gnt_o  (wr_gnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned      cyc;
    logic [NW*DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model [NW][NWORDS];
  int            checks = 0;
  int            failures = 0;

  // Requesters must hold req and fields until granted.
  a_hold_rd: assert property (@(posedge clk) disable iff (rst)
    (rd_req && !rd_gnt) |=> (rd_req && $stable(rd_idx)))
    else begin failures++; $display("FAIL handshake_rd cyc=%0d read request changed before grant", cyc); end
  a_hold_wr: assert property (@(posedge clk) disable iff (rst)
    (wr_req && !wr_gnt) |=> (wr_req && $stable(wr_idx) && $stable(wr_way) && $stable(wr_be) && $stable(wr_data)))
    else begin failures++; $display("FAIL handshake_wr cyc=%0d write request changed before grant", cyc); end

  // Scoreboard: every valid pulse pops the oldest expected read.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0) begin
      checks++;
      if ((rd_gnt & wr_gnt) !== 1'b0) begin
        failures++;
        $display("FAIL gnt_exclusive cyc=%0d got rd=%b wr=%b want not both", cyc, rd_gnt, wr_gnt);
      end
      if (rd_vld === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL rd_vld_spurious cyc=%0d got rd_vld=1 want 0", cyc);
        end else begin
          e = sb.pop_front();
          if (rd_data !== e.data || cyc != e.cyc) begin
            failures++;
            $display("FAIL rd_data cyc=%0d want_cyc=%0d got=%h want=%h", cyc, e.cyc, rd_data, e.data);
          end
        end
      end
    end
  end

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] d;
    for (int i = 0; i < int'(DW / 32); i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle, sample outputs mid-cycle, update the model from the expected grants.
  task automatic cycle_op(input bit rd, input dcache_idx_t ridx, input bit wr, input dcache_idx_t widx,
                          input dcache_way_oh_t way, input dcache_be_t be, input logic [DW-1:0] data,
                          input bit exp_rd, input bit exp_wr,
                          output logic got_rd, output logic got_wr, output logic got_vld);
    exp_t e;
    rd_req = rd; rd_idx = ridx;
    wr_req = wr; wr_idx = widx; wr_way = way; wr_be = be; wr_data = data;
    @(negedge clk);
    got_rd = rd_gnt; got_wr = wr_gnt; got_vld = rd_vld;
    if (exp_wr) begin
      for (int w = 0; w < int'(NW); w++)
        for (int b = 0; b < int'(BW); b++)
          if (way[w] && be[b]) model[w][widx][b*8 +: 8] = data[b*8 +: 8];
    end
    if (exp_rd) begin
      e.cyc = cyc + LAT;
      for (int w = 0; w < int'(NW); w++) e.data[w*DW +: DW] = model[w][ridx];
      sb.push_back(e);
    end
    next_cycle();
  endtask

  task automatic idle(input int n);
    logic g_rd, g_wr, g_v;
    for (int i = 0; i < n; i++) cycle_op(0, '0, 0, '0, '0, '0, '0, 0, 0, g_rd, g_wr, g_v);
  endtask

  task automatic drain(input string name);
    idle(int'(LAT) + 2);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_drain cyc=%0d got %0d reads outstanding want 0", name, cyc, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    logic g_rd, g_wr, g_v;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle_op(1, 6'd1, 1, 6'd2, 4'b0001, '1, '1, 0, 0, g_rd, g_wr, g_v);
      checks++;
      if ({g_rd, g_wr, g_v} !== 3'b000) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d got gnt=%b%b vld=%b want 000", cyc, g_rd, g_wr, g_v);
      end
    end
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({rd_gnt, wr_gnt, rd_vld} !== 3'b000) begin
      failures++;
      $display("FAIL reset_release cyc=%0d got gnt=%b%b vld=%b want 000", cyc, rd_gnt, wr_gnt, rd_vld);
    end
`ifdef RISCMAKERS_DCACHE_DATA_OUT_REG_EN
    checks++;
    if (rd_data !== '0) begin
      failures++;
      $display("FAIL reset_out_reg cyc=%0d got=%h want 0", cyc, rd_data);
    end
`endif
    next_cycle();
  endtask

  task automatic test_init();
    logic g_rd, g_wr, g_v;
    for (int i = 0; i < 16; i++)
      for (int w = 0; w < int'(NW); w++) begin
        cycle_op(0, '0, 1, 6'(i), 4'(1 << w), '1, rand_line(), 0, 1, g_rd, g_wr, g_v);
        checks++;
        if ({g_rd, g_wr} !== 2'b01) begin
          failures++;
          $display("FAIL init_wr_gnt cyc=%0d got rd=%b wr=%b want rd=0 wr=1", cyc, g_rd, g_wr);
        end
      end
  endtask

  task automatic test_write_read(input string name, input dcache_be_t be, input logic [DW-1:0] data);
    logic g_rd, g_wr, g_v;
    cycle_op(0, '0, 1, 6'd5, 4'b0010, be, data, 0, 1, g_rd, g_wr, g_v);
    checks++;
    if ({g_rd, g_wr} !== 2'b01) begin
      failures++;
      $display("FAIL %s_wr_gnt cyc=%0d got rd=%b wr=%b want rd=0 wr=1", name, cyc, g_rd, g_wr);
    end
    cycle_op(1, 6'd5, 0, '0, '0, '0, '0, 1, 0, g_rd, g_wr, g_v);
    checks++;
    if ({g_rd, g_wr} !== 2'b10) begin
      failures++;
      $display("FAIL %s_rd_gnt cyc=%0d got rd=%b wr=%b want rd=1 wr=0", name, cyc, g_rd, g_wr);
    end
    drain(name);
  endtask

  task automatic test_starvation();
    logic g_rd, g_wr, g_v;
    bit exp_rd;
    dcache_idx_t ridx = '0;
    logic [DW-1:0] d = rand_line();
    for (int k = 0; k < 10; k++) begin
      exp_rd = !(k == 4 || k == 9);
      cycle_op(1, ridx, 1, 6'd9, 4'b0100, '1, d, exp_rd, !exp_rd, g_rd, g_wr, g_v);
      checks++;
      if ({g_rd, g_wr} !== {exp_rd, !exp_rd}) begin
        failures++;
        $display("FAIL starve_k%0d cyc=%0d got rd=%b wr=%b want rd=%b wr=%b", k, cyc, g_rd, g_wr, exp_rd, !exp_rd);
      end
      if (exp_rd) ridx = ridx + 6'd1;
      else d = rand_line();
    end
    cycle_op(1, ridx, 0, '0, '0, '0, '0, 1, 0, g_rd, g_wr, g_v);
    checks++;
    if ({g_rd, g_wr} !== 2'b10) begin
      failures++;
      $display("FAIL starve_tail cyc=%0d got rd=%b wr=%b want rd=1 wr=0", cyc, g_rd, g_wr);
    end
    drain("starve");
  endtask

  task automatic test_raw();
    logic g_rd, g_wr, g_v;
    cycle_op(0, '0, 1, 6'd7, 4'b0001, '1, rand_line(), 0, 1, g_rd, g_wr, g_v);
    cycle_op(1, 6'd7, 0, '0, '0, '0, '0, 1, 0, g_rd, g_wr, g_v);
    checks++;
    if (g_rd !== 1'b1) begin
      failures++;
      $display("FAIL raw_rd_gnt cyc=%0d got %b want 1", cyc, g_rd);
    end
    drain("raw");
  endtask

  task automatic test_enables();
    logic g_rd, g_wr, g_v;
    cycle_op(0, '0, 1, 6'd7, 4'b0000, '1, rand_line(), 0, 1, g_rd, g_wr, g_v);
    checks++;
    if (g_wr !== 1'b1) begin failures++; $display("FAIL noway_gnt cyc=%0d got %b want 1", cyc, g_wr); end
    cycle_op(0, '0, 1, 6'd7, 4'b0001, '0, rand_line(), 0, 1, g_rd, g_wr, g_v);
    checks++;
    if (g_wr !== 1'b1) begin failures++; $display("FAIL nobe_gnt cyc=%0d got %b want 1", cyc, g_wr); end
    cycle_op(0, '0, 1, 6'd3, 4'b1111, 16'hF0F0, rand_line(), 0, 1, g_rd, g_wr, g_v);
    cycle_op(1, 6'd7, 0, '0, '0, '0, '0, 1, 0, g_rd, g_wr, g_v);
    cycle_op(1, 6'd3, 0, '0, '0, '0, '0, 1, 0, g_rd, g_wr, g_v);
    drain("enables");
  endtask

  task automatic test_back_to_back();
    logic g_rd, g_wr, g_v;
    for (int i = 0; i < 8; i++) begin
      cycle_op(1, 6'($urandom_range(0, 15)), 0, '0, '0, '0, '0, 1, 0, g_rd, g_wr, g_v);
      checks++;
      if (g_rd !== 1'b1) begin failures++; $display("FAIL b2b_rd_gnt_%0d cyc=%0d got %b want 1", i, cyc, g_rd); end
    end
    drain("b2b");
  endtask

  task automatic test_reset_mid();
    logic g_rd, g_wr, g_v;
    bit exp_rd;
    for (int k = 1; k <= 3; k++) cycle_op(1, 6'(k), 1, 6'd4, 4'b0001, '1, '0, 1, 0, g_rd, g_wr, g_v);
    rst = 1'b1;
    cycle_op(1, 6'd3, 1, 6'd4, 4'b0001, '1, '0, 0, 0, g_rd, g_wr, g_v);
    checks++;
    if ({g_rd, g_wr, g_v} !== 3'b000) begin
      failures++;
      $display("FAIL rstmid_during cyc=%0d got gnt=%b%b vld=%b want 000", cyc, g_rd, g_wr, g_v);
    end
    sb.delete();
    cycle_op(0, '0, 0, '0, '0, '0, '0, 0, 0, g_rd, g_wr, g_v);
    checks++;
    if (g_v !== 1'b0) begin failures++; $display("FAIL rstmid_vld cyc=%0d got %b want 0", cyc, g_v); end
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      exp_rd = (k != 4);
      cycle_op(1, 6'(8 + (k > 3 ? 3 : k)), 1, 6'd10, 4'b1000, '1, '1, exp_rd, !exp_rd, g_rd, g_wr, g_v);
      checks++;
      if ({g_rd, g_wr} !== {exp_rd, !exp_rd}) begin
        failures++;
        $display("FAIL rstmid_cnt_k%0d cyc=%0d got rd=%b wr=%b want rd=%b wr=%b", k, cyc, g_rd, g_wr, exp_rd, !exp_rd);
      end
    end
    cycle_op(1, 6'd11, 0, '0, '0, '0, '0, 1, 0, g_rd, g_wr, g_v);
    drain("rstmid");
  endtask

  initial begin
    next_cycle();
    test_reset();
    test_init();
    test_write_read("full", '1, {BW{8'hA5}});
    test_write_read("partial", 16'h0001, DW'(8'h3C));
    test_starvation();
    test_raw();
    test_enables();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
